// File: rtl/axis_video_frame_checker.sv
// axis_video_frame_checker
// AXI-Stream video sink for test benches. It accepts pixel beats, drives back-pressure
// on tready_s, checks frame structure and reports a per-frame data sum. The back-pressure
// is either constant or derived from an LFSR.
// A valid frame marks tuser only on its first pixel and tlast only on the last pixel
// of each line.
//
// Ports:
//   aclk, areset            clock; asynchronous active-high reset
//   tdata_s, tlast_s,       incoming AXI-Stream pixel, end-of-line, start-of-frame
//   tuser_s, tvalid_s
//   tready_s                registered sink ready (constant 1 or LFSR-driven)
//   frame_done, frame_ok    one-cycle completion pulse and its qualifier
//   frame_sum               sum of tdata_s over the last completed frame (mod 2^32)
//   frame_count             completed frames (wraps)
//   err_count               mismatching beats (saturates)
//   err_sof, err_eol        sticky tuser / tlast mismatch flags
module axis_video_frame_checker #(
    parameter int unsigned DW          = 16,
    parameter int unsigned ACTIVE_HORI = 1366,
    parameter int unsigned ACTIVE_VERT = 768,
    parameter int unsigned READY_MODE  = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [DW-1:0] tdata_s,
    input  logic          tlast_s,
    input  logic          tuser_s,
    input  logic          tvalid_s,
    output logic          tready_s,
    output logic          frame_done,
    output logic          frame_ok,
    output logic [31:0]   frame_sum,
    output logic [15:0]   frame_count,
    output logic [15:0]   err_count,
    output logic          err_sof,
    output logic          err_eol
);

    localparam int unsigned PW = (ACTIVE_HORI > 1) ? $clog2(ACTIVE_HORI) : 1;
    localparam int unsigned VW = (ACTIVE_VERT > 1) ? $clog2(ACTIVE_VERT) : 1;
    localparam logic [PW-1:0] LAST_PIX  = PW'(ACTIVE_HORI - 1);
    localparam logic [VW-1:0] LAST_LINE = VW'(ACTIVE_VERT - 1);

    typedef enum logic {SYNC, RUN} state_t;

    state_t          state, state_next;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic [PW-1:0]   pixels;
    logic [VW-1:0]   lines;
    logic [31:0]     sum;
    logic            frame_err;

    logic            beat;
    logic            exp_sof, exp_eol;
    logic            sof_bad, eol_bad, mismatch;
    logic            at_last;

    // FSM-decoded actions
    logic            load_first;
    logic            accumulate;
    logic            finish_frame;
    logic            flag_err;

    assign beat     = tvalid_s && tready_s;
    assign exp_sof  = (pixels == '0) && (lines == '0);
    assign exp_eol  = (pixels == LAST_PIX);
    assign sof_bad  = (tuser_s != exp_sof);
    assign eol_bad  = (tlast_s != exp_eol);
    assign mismatch = sof_bad || eol_bad;
    assign at_last  = (pixels == LAST_PIX) && (lines == LAST_LINE);

    // Galois LFSR, right shift
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            SYNC: if (beat && tuser_s) state_next = RUN;
            RUN:  if (beat && mismatch && !tuser_s) state_next = SYNC;
            default: state_next = SYNC;
        endcase
    end

    // Action decode. A mismatching beat carrying tuser acts as a fresh pixel (0,0).
    always_comb begin
        load_first   = 1'b0;
        accumulate   = 1'b0;
        finish_frame = 1'b0;
        flag_err     = 1'b0;
        case (state)
            SYNC: load_first = beat && tuser_s;
            RUN: begin
                if (beat) begin
                    if (mismatch) begin
                        flag_err   = 1'b1;
                        load_first = tuser_s;
                    end else begin
                        accumulate   = 1'b1;
                        finish_frame = at_last;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath, counters and status
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lfsr        <= LFSR_SEED;
            tready_s    <= 1'b0;
            pixels      <= '0;
            lines       <= '0;
            sum         <= '0;
            frame_err   <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_sum   <= '0;
            frame_count <= '0;
            err_count   <= '0;
            err_sof     <= 1'b0;
            err_eol     <= 1'b0;
        end else begin
            lfsr       <= lfsr_next;
            tready_s   <= (READY_MODE != 0) ? (lfsr[1:0] != 2'b00) : 1'b1;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;

            if (flag_err) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (sof_bad) err_sof <= 1'b1;
                if (eol_bad) err_eol <= 1'b1;
                frame_err <= 1'b1;
            end

            // Placed after the error update so a restart clears the frame flag.
            if (load_first) begin
                pixels    <= PW'(1);
                lines     <= '0;
                sum       <= 32'(tdata_s);
                frame_err <= 1'b0;
            end else if (accumulate) begin
                if (finish_frame) begin
                    frame_sum   <= sum + 32'(tdata_s);
                    frame_count <= frame_count + 16'd1;
                    frame_done  <= 1'b1;
                    frame_ok    <= !frame_err;
                    sum         <= '0;
                    pixels      <= '0;
                    lines       <= '0;
                end else begin
                    sum <= sum + 32'(tdata_s);
                    if (pixels == LAST_PIX) begin
                        pixels <= '0;
                        lines  <= lines + VW'(1);
                    end else begin
                        pixels <= pixels + PW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_video_frame_checker.sv
// Directed bench for axis_video_frame_checker using a 4x3 frame.
// dut0 runs with constant ready. dut1 runs with LFSR back-pressure and has its own reset.
module tb_axis_video_frame_checker;

    localparam int unsigned H = 4;
    localparam int unsigned V = 3;

    logic        clk = 1'b0;
    logic        areset;
    logic [15:0] tdata;
    logic        tlast, tuser, tvalid;
    logic        tready, frame_done, frame_ok, err_sof, err_eol;
    logic [31:0] frame_sum;
    logic [15:0] frame_count, err_count;

    logic        rst1;
    logic [15:0] tdata1;
    logic        tlast1, tuser1, tvalid1;
    logic        tready1, frame_done1, frame_ok1, err_sof1, err_eol1;
    logic [31:0] frame_sum1;
    logic [15:0] frame_count1, err_count1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    axis_video_frame_checker #(.DW(16), .ACTIVE_HORI(H), .ACTIVE_VERT(V),
                               .READY_MODE(0), .LFSR_SEED(16'hACE1)) dut0 (
        .aclk(clk), .areset(areset), .tdata_s(tdata), .tlast_s(tlast),
        .tuser_s(tuser), .tvalid_s(tvalid), .tready_s(tready),
        .frame_done(frame_done), .frame_ok(frame_ok), .frame_sum(frame_sum),
        .frame_count(frame_count), .err_count(err_count),
        .err_sof(err_sof), .err_eol(err_eol));

    axis_video_frame_checker #(.DW(16), .ACTIVE_HORI(H), .ACTIVE_VERT(V),
                               .READY_MODE(1), .LFSR_SEED(16'hACE1)) dut1 (
        .aclk(clk), .areset(rst1), .tdata_s(tdata1), .tlast_s(tlast1),
        .tuser_s(tuser1), .tvalid_s(tvalid1), .tready_s(tready1),
        .frame_done(frame_done1), .frame_ok(frame_ok1), .frame_sum(frame_sum1),
        .frame_count(frame_count1), .err_count(err_count1),
        .err_sof(err_sof1), .err_eol(err_eol1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One beat on dut0. Inputs are driven 1 time unit after an edge, and outputs are sampled there too.
    task automatic beat(input logic [15:0] d, input logic u, input logic l);
        tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
        chk("tready_const", {31'd0, tready}, 32'd1);
        @(posedge clk); #1;
        tvalid = 1'b0;
    endtask

    // Pixel index i of a 4x3 frame. Its data is i+1 and tlast is set on the 4th pixel of each line.
    task automatic px(input int unsigned i, input logic u);
        beat(16'(i + 1), u, (i % H) == H - 1);
    endtask

    task automatic send_frame(input logic first_user, input logic expect_done,
                              input logic [15:0] exp_count);
        for (int i = 0; i < 12; i++) begin
            px(i, (i == 0) ? first_user : 1'b0);
            if (i == 0) chk("done_one_cycle", {31'd0, frame_done}, 32'd0);
        end
        if (expect_done) begin
            chk("frame_done", {31'd0, frame_done}, 32'd1);
            chk("frame_ok", {31'd0, frame_ok}, 32'd1);
            chk("frame_sum", frame_sum, 32'd78);
        end else begin
            chk("no_done", {31'd0, frame_done}, 32'd0);
        end
        chk("frame_count", {16'd0, frame_count}, {16'd0, exp_count});
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    initial begin
        logic [15:0] m_lfsr;
        logic        m_rdy;
        logic        acc;
        int unsigned k;

        areset = 1'b1; rst1 = 1'b1;
        tdata = '0; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b0;
        tdata1 = '0; tlast1 = 1'b0; tuser1 = 1'b0; tvalid1 = 1'b0;

        // Reset state
        #2;
        chk("rst_tready", {31'd0, tready}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_count", {16'd0, frame_count}, 32'd0);
        chk("rst_sum", frame_sum, 32'd0);
        @(posedge clk); #1;
        areset = 1'b0;
        chk("tready_held_low", {31'd0, tready}, 32'd0);
        @(posedge clk); #1;
        chk("tready_cycle1", {31'd0, tready}, 32'd1);

        // Pre-sync junk, then two back-to-back clean frames
        for (int i = 0; i < 5; i++) beat(16'(100 + i), 1'b0, 1'b0);
        chk("junk_err", {16'd0, err_count}, 32'd0);
        chk("junk_count", {16'd0, frame_count}, 32'd0);
        send_frame(1'b1, 1'b1, 16'd1);
        send_frame(1'b1, 1'b1, 16'd2);
        chk("clean_err", {16'd0, err_count}, 32'd0);
        chk("clean_sof", {31'd0, err_sof}, 32'd0);

        // Missing SOF
        send_frame(1'b0, 1'b0, 16'd2);
        chk("miss_sof_flag", {31'd0, err_sof}, 32'd1);
        chk("miss_sof_eol", {31'd0, err_eol}, 32'd0);
        chk("miss_sof_cnt", {16'd0, err_count}, 32'd1);
        send_frame(1'b1, 1'b1, 16'd3);

        // Early tlast at pixel 2 of line 0
        beat(16'd1, 1'b1, 1'b0);
        beat(16'd2, 1'b0, 1'b0);
        beat(16'd3, 1'b0, 1'b1);
        chk("early_eol_flag", {31'd0, err_eol}, 32'd1);
        chk("early_eol_cnt", {16'd0, err_count}, 32'd2);
        beat(16'd4, 1'b0, 1'b0);
        chk("sync_discard", {16'd0, err_count}, 32'd2);

        // Mid-frame tuser restarts the frame
        for (int i = 0; i < 5; i++) px(i, i == 0);
        px(0, 1'b1);
        chk("restart_cnt", {16'd0, err_count}, 32'd3);
        for (int i = 1; i < 12; i++) px(i, 1'b0);
        chk("restart_done", {31'd0, frame_done}, 32'd1);
        chk("restart_sum", frame_sum, 32'd78);
        chk("restart_count", {16'd0, frame_count}, 32'd4);

        // Reset mid-frame, asserted between clock edges
        for (int i = 0; i < 5; i++) px(i, i == 0);
        #3 areset = 1'b1;
        #1;
        chk("mid_rst_tready", {31'd0, tready}, 32'd0);
        chk("mid_rst_count", {16'd0, frame_count}, 32'd0);
        chk("mid_rst_err", {16'd0, err_count}, 32'd0);
        chk("mid_rst_flags", {30'd0, err_sof, err_eol}, 32'd0);
        chk("mid_rst_sum", frame_sum, 32'd0);
        #1 areset = 1'b0;
        @(posedge clk); #1;
        for (int i = 5; i < 12; i++) px(i, 1'b0);
        chk("post_rst_nodone", {16'd0, frame_count}, 32'd0);
        send_frame(1'b1, 1'b1, 16'd1);
        chk("post_rst_err", {16'd0, err_count}, 32'd0);

        // LFSR back-pressure on dut1. The source holds tvalid high.
        #3 rst1 = 1'b0;
        m_lfsr = 16'hACE1;
        k = 0;
        for (int cyc = 0; cyc < 300 && k < 24; cyc++) begin
            tvalid1 = 1'b1;
            tdata1  = 16'((k % 12) + 1);
            tuser1  = (k % 12) == 0;
            tlast1  = (k % H) == H - 1;
            acc = tready1;
            @(posedge clk); #1;
            m_rdy  = (m_lfsr[1:0] != 2'b00);
            m_lfsr = lfsr_step(m_lfsr);
            chk("bp_tready", {31'd0, tready1}, {31'd0, m_rdy});
            if (acc) begin
                k++;
                if (k == 12 || k == 24) begin
                    chk("bp_done", {31'd0, frame_done1}, 32'd1);
                    chk("bp_sum", frame_sum1, 32'd78);
                    chk("bp_count", {16'd0, frame_count1}, k / 12);
                end
            end
        end
        tvalid1 = 1'b0;
        chk("bp_all_beats", k, 32'd24);
        chk("bp_err", {16'd0, err_count1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
